// File: rtl/seq_detector_param_pkg.sv
// Shared constants and helpers for the parametrised serial-pattern detector.
package seq_det_pkg;
  localparam int                   DEF_PAT_W   = 4;
  localparam int                   DEF_CNT_W   = 8;
  localparam logic [DEF_PAT_W-1:0] DEF_PAT_RST = 4'b1010;
  localparam int                   CNT_MAX     = (1 << DEF_CNT_W) - 1;

  // fill must be able to hold the value PAT_W itself, hence the +1
  function automatic int fill_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction
endpackage

// File: rtl/seq_detector_param_if.sv
// Control/data bundle between the serial source and the pattern detector.
interface seq_detector_param_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             x;
  logic             en;
  logic             ovl_en;
  logic             pat_we;
  logic [PAT_W-1:0] pat_in;
  logic [PAT_W-1:0] mask_in;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output x, en, ovl_en, pat_we, pat_in, mask_in, cnt_clr,
    input  z, match_cnt
  );

  modport slave (
    input  x, en, ovl_en, pat_we, pat_in, mask_in, cnt_clr,
    output z, match_cnt
  );
endinterface

// File: rtl/seq_hist_shreg.sv
// Serial history shift register with a saturating count of valid bits held.
module seq_hist_shreg
  import seq_det_pkg::*;
#(
  parameter int PAT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_shift,
  input  logic             i_restart,
  input  logic             i_x,
  output logic [PAT_W-1:0] o_hist_n,
  output logic             o_full_n
);
  localparam int             FW       = fill_w(PAT_W);
  localparam logic [FW-1:0]  FILL_MAX = FW'(PAT_W);

  logic [PAT_W-1:0] r_hist;
  logic [FW-1:0]    r_fill;
  logic [FW-1:0]    w_fill_n;

  assign o_hist_n = {r_hist[PAT_W-2:0], i_x};
  assign w_fill_n = (r_fill == FILL_MAX) ? r_fill : r_fill + 1'b1;
  assign o_full_n = (w_fill_n == FILL_MAX);

  // i_clr only forgets how many bits are valid; stale history is harmless
  // because no hit is possible until PAT_W fresh bits have been shifted in.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
    end else if (i_clr) begin
      r_fill <= '0;
    end else if (i_shift) begin
      r_hist <= o_hist_n;
      r_fill <= i_restart ? '0 : w_fill_n;
    end
  end
endmodule

// File: rtl/seq_detector_param.sv
// Moore detector for a runtime-loadable masked pattern with a saturating match counter.
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(DEF_PAT_RST),
  parameter int               CNT_W   = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_detector_param_if.slave  bus
);
  localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-1:0] r_mask;
  logic             r_z;
  logic [CNT_W-1:0] r_cnt;

  logic [PAT_W-1:0] w_hist_n;
  logic             w_full_n;
  logic             w_shift;
  logic             w_hit;
  logic             w_take;

  // a pattern load on the same edge swallows the sample
  assign w_shift = bus.en & ~bus.pat_we;
  assign w_hit   = w_full_n & ~|((w_hist_n ^ r_pat) & r_mask);
  assign w_take  = w_shift & w_hit;

  seq_hist_shreg #(.PAT_W(PAT_W)) u_hist (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (bus.pat_we),
    .i_shift   (w_shift),
    .i_restart (w_hit & ~bus.ovl_en),
    .i_x       (bus.x),
    .o_hist_n  (w_hist_n),
    .o_full_n  (w_full_n)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pat  <= PAT_RST;
      r_mask <= '1;
      r_z    <= 1'b0;
      r_cnt  <= '0;
    end else begin
      if (bus.pat_we) begin
        r_pat  <= bus.pat_in;
        r_mask <= bus.mask_in;
      end
      r_z <= w_take;
      if (bus.cnt_clr)
        r_cnt <= '0;
      else if (w_take && r_cnt != C_MAX)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  assign bus.z         = r_z;
  assign bus.match_cnt = r_cnt;
endmodule

// File: tb/tb_seq_detector_param.sv
// Bench: two detector instances (8-bit and 2-bit counters) against a queue-based reference.
module tb_seq_detector_param;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_param_if #(.PAT_W(4), .CNT_W(8)) bus8 ();
  seq_detector_param_if #(.PAT_W(4), .CNT_W(2)) bus2 ();

  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1010), .CNT_W(8)) u_dut8 (
    .clk(clk), .reset(rst), .bus(bus8.slave));
  seq_detector_param #(.PAT_W(4), .PAT_RST(4'b1010), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(rst), .bus(bus2.slave));

  int total = 0;
  int bad   = 0;

  // reference: the most recent fresh samples, oldest at index 0
  bit       mq[$];
  bit [3:0] mpat;
  bit [3:0] mmask;
  bit       mz;
  int       c8, c2;

  function automatic bit window_match();
    for (int i = 0; i < 4; i++)
      if (mmask[3-i] && (mq[i] != mpat[3-i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rs, input bit x, input bit en, input bit ovl,
                      input bit we, input bit [3:0] p, input bit [3:0] m, input bit clr);
    rst = rs;
    bus8.x = x;  bus8.en = en;  bus8.ovl_en = ovl;  bus8.pat_we = we;
    bus8.pat_in = p;  bus8.mask_in = m;  bus8.cnt_clr = clr;
    bus2.x = x;  bus2.en = en;  bus2.ovl_en = ovl;  bus2.pat_we = we;
    bus2.pat_in = p;  bus2.mask_in = m;  bus2.cnt_clr = clr;
    if (rs) begin
      mq.delete(); mpat = 4'b1010; mmask = 4'hf; mz = 0; c8 = 0; c2 = 0;
    end else begin
      if (we) begin
        mpat = p; mmask = m; mq.delete(); mz = 0;
      end else if (en) begin
        mq.push_back(x);
        if (mq.size() > 4) void'(mq.pop_front());
        mz = (mq.size() == 4) && window_match();
        if (mz && !ovl) mq.delete();
      end else begin
        mz = 0;
      end
      if (clr) begin
        c8 = 0; c2 = 0;
      end else if (mz) begin
        if (c8 < 255) c8++;
        if (c2 < 3) c2++;
      end
    end
    @(posedge clk);
    #1;
    chk("z8",   {31'b0, bus8.z},        {31'b0, mz});
    chk("cnt8", {24'b0, bus8.match_cnt}, c8);
    chk("z2",   {31'b0, bus2.z},        {31'b0, mz});
    chk("cnt2", {30'b0, bus2.match_cnt}, c2);
  endtask

  task automatic bits(input bit ovl, input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) step(0, v[i], 1, ovl, 0, 4'h0, 4'h0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 4'h0, 4'h0, 0);
  endtask

  initial begin
    // reset state
    do_reset();
    do_reset();
    chk("rst_z",   {31'b0, bus8.z}, 32'd0);
    chk("rst_cnt", {24'b0, bus8.match_cnt}, 32'd0);

    // T1 overlap
    bits(1, 32'b110101011101010, 15);
    chk("t1_cnt", {24'b0, bus8.match_cnt}, 32'd4);

    // T2 non-overlap
    do_reset();
    bits(0, 32'b110101011101010, 15);
    chk("t2_cnt", {24'b0, bus8.match_cnt}, 32'd2);

    // T3 masked pattern 101x
    do_reset();
    step(0, 0, 1, 1, 1, 4'b1010, 4'b1110, 0);
    bits(1, 32'b101, 3);
    chk("t3_nofill", {31'b0, bus8.z}, 32'd0);
    bits(1, 32'b1, 1);
    chk("t3_hit1", {31'b0, bus8.z}, 32'd1);
    bits(1, 32'b011, 3);
    chk("t3_hit2", {31'b0, bus8.z}, 32'd1);

    // T4 enable gaps, then reload on the final bit
    do_reset();
    bits(1, 32'b101, 3);
    for (int i = 0; i < 3; i++) step(0, 1'($urandom), 0, 1, 0, 4'h0, 4'h0, 0);
    bits(1, 32'b0, 1);
    chk("t4_gap_hit", {31'b0, bus8.z}, 32'd1);
    bits(1, 32'b101, 3);
    step(0, 0, 1, 1, 1, 4'b1010, 4'b1111, 0);
    chk("t4_reload_z", {31'b0, bus8.z}, 32'd0);
    bits(1, 32'b010, 3);
    chk("t4_fill_zero", {31'b0, bus8.z}, 32'd0);

    // T5 saturation on the 2-bit counter, then clear against a hit
    do_reset();
    bits(1, 32'b101010101010, 12);
    chk("t5_sat", {30'b0, bus2.match_cnt}, 32'd3);
    chk("t5_cnt8", {24'b0, bus8.match_cnt}, 32'd5);
    step(0, 1, 1, 1, 0, 4'h0, 4'h0, 0);
    step(0, 0, 1, 1, 0, 4'h0, 4'h0, 1);
    chk("t5_clr_z",   {31'b0, bus2.z}, 32'd1);
    chk("t5_clr_cnt", {30'b0, bus2.match_cnt}, 32'd0);

    // T6 reset mid-stream, pattern returns to 1010
    step(0, 1, 1, 1, 1, 4'b0110, 4'b1111, 0);
    bits(1, 32'b101, 3);
    do_reset();
    chk("t6_z",   {31'b0, bus8.z}, 32'd0);
    chk("t6_cnt", {24'b0, bus8.match_cnt}, 32'd0);
    bits(1, 32'b0, 1);
    chk("t6_nohit", {31'b0, bus8.z}, 32'd0);
    bits(1, 32'b1010, 4);
    chk("t6_patrst", {31'b0, bus8.z}, 32'd1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      bit rs, we, clr, en, ovl;
      bit [3:0] p, m;
      rs  = ($urandom_range(0, 99) == 0);
      we  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      en  = ($urandom_range(0, 9) < 8);
      ovl = ($urandom_range(0, 9) < 6);
      p   = 4'($urandom);
      m   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hf;
      step(rs, 1'($urandom), en, ovl, we, p, m, clr);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
